// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: multiplexes NUM_CONSUMERS memory request ports onto
// NUM_CHANNELS memory channels using the valid/ready memory protocol.
//
// Optional feature macro: MEM_ARB_WRITE_EN
//   defined   - read and write paths are present.
//   undefined - read-only arbiter. The write outputs are tied to 0 and the
//               write requests are ignored.
//
// Handshake: the initiator raises *_valid and holds address/data stable.
// The transfer completes on the cycle the responder returns *_ready=1, and
// valid drops after that edge. On the consumer side the roles are reversed.
// consumer_*_ready is raised when the memory transfer completes. It is held
// until the consumer drops its valid, and the consumer then owns no channel.
//
// Each channel runs its own FSM: IDLE, READ_WAIT, READ_RELAY, WRITE_WAIT,
// WRITE_RELAY. The state_q array holds the state of every channel and can be
// probed directly. The serving mask records which consumers a channel owns.
module mem_req_arbiter #(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8,
  parameter int NUM_CONSUMERS = 4,
  parameter int NUM_CHANNELS  = 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NUM_CONSUMERS-1:0]             consumer_read_valid,
  input  logic [ADDR_BITS*NUM_CONSUMERS-1:0]   consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]             consumer_read_ready,
  output logic [DATA_BITS*NUM_CONSUMERS-1:0]   consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]             consumer_write_valid,
  input  logic [ADDR_BITS*NUM_CONSUMERS-1:0]   consumer_write_address,
  input  logic [DATA_BITS*NUM_CONSUMERS-1:0]   consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]             consumer_write_ready,
  output logic [NUM_CHANNELS-1:0]              mem_read_valid,
  output logic [ADDR_BITS*NUM_CHANNELS-1:0]    mem_read_address,
  input  logic [NUM_CHANNELS-1:0]              mem_read_ready,
  input  logic [DATA_BITS*NUM_CHANNELS-1:0]    mem_read_data,
  output logic [NUM_CHANNELS-1:0]              mem_write_valid,
  output logic [ADDR_BITS*NUM_CHANNELS-1:0]    mem_write_address,
  output logic [DATA_BITS*NUM_CHANNELS-1:0]    mem_write_data,
  input  logic [NUM_CHANNELS-1:0]              mem_write_ready
);

  localparam int OW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    READ_WAIT   = 3'd1,
    READ_RELAY  = 3'd2
`ifdef MEM_ARB_WRITE_EN
    ,
    WRITE_WAIT  = 3'd3,
    WRITE_RELAY = 3'd4
`endif
  } state_t;

  state_t                   state_q [NUM_CHANNELS];
  state_t                   state_d [NUM_CHANNELS];
  logic [OW-1:0]            owner_q [NUM_CHANNELS];
  logic [OW-1:0]            owner_d [NUM_CHANNELS];

  logic [NUM_CONSUMERS-1:0] serving;
  logic [NUM_CONSUMERS-1:0] serving_d;
  logic [NUM_CONSUMERS-1:0] serving_v;
  logic [NUM_CONSUMERS-1:0] release_mask;
  logic [NUM_CONSUMERS-1:0] req;
  logic                     found;
  logic [OW-1:0]            pick;

  logic [NUM_CHANNELS-1:0]            mem_read_valid_d;
  logic [ADDR_BITS*NUM_CHANNELS-1:0]  mem_read_address_d;
  logic [NUM_CONSUMERS-1:0]           consumer_read_ready_d;
  logic [DATA_BITS*NUM_CONSUMERS-1:0] consumer_read_data_d;

`ifdef MEM_ARB_WRITE_EN
  logic [NUM_CHANNELS-1:0]            mem_write_valid_d;
  logic [ADDR_BITS*NUM_CHANNELS-1:0]  mem_write_address_d;
  logic [DATA_BITS*NUM_CHANNELS-1:0]  mem_write_data_d;
  logic [NUM_CONSUMERS-1:0]           consumer_write_ready_d;

  // A consumer competes for a channel with either kind of request.
  assign req = consumer_read_valid | consumer_write_valid;
`else
  logic unused_write_inputs;

  // In the read-only build only read requests compete for a channel.
  assign req = consumer_read_valid;
  assign unused_write_inputs = ^{consumer_write_valid, consumer_write_address,
                                 consumer_write_data, mem_write_ready};
  assign mem_write_valid      = '0;
  assign mem_write_address    = '0;
  assign mem_write_data       = '0;
  assign consumer_write_ready = '0;
`endif

  // Next state for every channel FSM, evaluated in channel index order. A
  // claim marks serving_v at once, so a higher-index channel cannot take the
  // same consumer in the same cycle. A release is applied only at the end, so
  // a freed consumer can be claimed again no earlier than the next cycle.
  always_comb begin
    serving_v             = serving;
    release_mask          = '0;
    found                 = 1'b0;
    pick                  = '0;
    mem_read_valid_d      = mem_read_valid;
    mem_read_address_d    = mem_read_address;
    consumer_read_ready_d = consumer_read_ready;
    consumer_read_data_d  = consumer_read_data;
`ifdef MEM_ARB_WRITE_EN
    mem_write_valid_d      = mem_write_valid;
    mem_write_address_d    = mem_write_address;
    mem_write_data_d       = mem_write_data;
    consumer_write_ready_d = consumer_write_ready;
`endif
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      state_d[c] = state_q[c];
      owner_d[c] = owner_q[c];
    end

    for (int c = 0; c < NUM_CHANNELS; c++) begin
      case (state_q[c])
        IDLE: begin
          found = 1'b0;
          pick  = '0;
          for (int i = 0; i < NUM_CONSUMERS; i++) begin
            if (!found && req[i] && !serving_v[i]) begin
              found = 1'b1;
              pick  = OW'(i);
            end
          end
          if (found) begin
            serving_v[pick] = 1'b1;
            owner_d[c]      = pick;
            // Read wins when the consumer has both requests valid.
            if (consumer_read_valid[pick]) begin
              state_d[c]          = READ_WAIT;
              mem_read_valid_d[c] = 1'b1;
              mem_read_address_d[c*ADDR_BITS +: ADDR_BITS] =
                consumer_read_address[pick*ADDR_BITS +: ADDR_BITS];
            end
`ifdef MEM_ARB_WRITE_EN
            else begin
              state_d[c]           = WRITE_WAIT;
              mem_write_valid_d[c] = 1'b1;
              mem_write_address_d[c*ADDR_BITS +: ADDR_BITS] =
                consumer_write_address[pick*ADDR_BITS +: ADDR_BITS];
              mem_write_data_d[c*DATA_BITS +: DATA_BITS] =
                consumer_write_data[pick*DATA_BITS +: DATA_BITS];
            end
`endif
          end
        end

        READ_WAIT: begin
          if (mem_read_ready[c]) begin
            state_d[c]                        = READ_RELAY;
            mem_read_valid_d[c]               = 1'b0;
            consumer_read_ready_d[owner_q[c]] = 1'b1;
            consumer_read_data_d[owner_q[c]*DATA_BITS +: DATA_BITS] =
              mem_read_data[c*DATA_BITS +: DATA_BITS];
          end
        end

        READ_RELAY: begin
          if (!consumer_read_valid[owner_q[c]]) begin
            state_d[c]                        = IDLE;
            consumer_read_ready_d[owner_q[c]] = 1'b0;
            release_mask[owner_q[c]]          = 1'b1;
          end
        end

`ifdef MEM_ARB_WRITE_EN
        WRITE_WAIT: begin
          if (mem_write_ready[c]) begin
            state_d[c]                         = WRITE_RELAY;
            mem_write_valid_d[c]               = 1'b0;
            consumer_write_ready_d[owner_q[c]] = 1'b1;
          end
        end

        WRITE_RELAY: begin
          if (!consumer_write_valid[owner_q[c]]) begin
            state_d[c]                         = IDLE;
            consumer_write_ready_d[owner_q[c]] = 1'b0;
            release_mask[owner_q[c]]           = 1'b1;
          end
        end
`endif

        default: state_d[c] = IDLE;
      endcase
    end

    serving_d = serving_v & ~release_mask;
  end

  // FSM state, ownership and every read-path output are registered. Reset
  // aborts any transaction that is in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        state_q[c] <= IDLE;
        owner_q[c] <= '0;
      end
      serving             <= '0;
      mem_read_valid      <= '0;
      mem_read_address    <= '0;
      consumer_read_ready <= '0;
      consumer_read_data  <= '0;
    end else begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        state_q[c] <= state_d[c];
        owner_q[c] <= owner_d[c];
      end
      serving             <= serving_d;
      mem_read_valid      <= mem_read_valid_d;
      mem_read_address    <= mem_read_address_d;
      consumer_read_ready <= consumer_read_ready_d;
      consumer_read_data  <= consumer_read_data_d;
    end
  end

`ifdef MEM_ARB_WRITE_EN
  // Registered write-path outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_write_valid      <= '0;
      mem_write_address    <= '0;
      mem_write_data       <= '0;
      consumer_write_ready <= '0;
    end else begin
      mem_write_valid      <= mem_write_valid_d;
      mem_write_address    <= mem_write_address_d;
      mem_write_data       <= mem_write_data_d;
      consumer_write_ready <= consumer_write_ready_d;
    end
  end
`endif

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed testbench for mem_req_arbiter. It uses one single-channel
// instance (a_*) and one two-channel instance (b_*). Write-path expectations
// follow MEM_ARB_WRITE_EN.
module tb_mem_req_arbiter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // ---------------- single-channel DUT signals ----------------
  logic [3:0]  a_crv, a_crr, a_cwv, a_cwr;
  logic [31:0] a_cra, a_crd, a_cwa, a_cwd;
  logic [0:0]  a_mrv, a_mrr, a_mwv, a_mwr;
  logic [7:0]  a_mra, a_mrd, a_mwa, a_mwd;

  // ---------------- two-channel DUT signals ----------------
  logic [3:0]  b_crv, b_crr, b_cwv, b_cwr;
  logic [31:0] b_cra, b_crd, b_cwa, b_cwd;
  logic [1:0]  b_mrv, b_mrr, b_mwv, b_mwr;
  logic [15:0] b_mra, b_mrd, b_mwa, b_mwd;

  mem_req_arbiter #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(4), .NUM_CHANNELS(1)) u_a (
    .clk(clk), .rst_n(rst_n),
    .consumer_read_valid(a_crv), .consumer_read_address(a_cra),
    .consumer_read_ready(a_crr), .consumer_read_data(a_crd),
    .consumer_write_valid(a_cwv), .consumer_write_address(a_cwa),
    .consumer_write_data(a_cwd), .consumer_write_ready(a_cwr),
    .mem_read_valid(a_mrv), .mem_read_address(a_mra),
    .mem_read_ready(a_mrr), .mem_read_data(a_mrd),
    .mem_write_valid(a_mwv), .mem_write_address(a_mwa),
    .mem_write_data(a_mwd), .mem_write_ready(a_mwr)
  );

  mem_req_arbiter #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(4), .NUM_CHANNELS(2)) u_b (
    .clk(clk), .rst_n(rst_n),
    .consumer_read_valid(b_crv), .consumer_read_address(b_cra),
    .consumer_read_ready(b_crr), .consumer_read_data(b_crd),
    .consumer_write_valid(b_cwv), .consumer_write_address(b_cwa),
    .consumer_write_data(b_cwd), .consumer_write_ready(b_cwr),
    .mem_read_valid(b_mrv), .mem_read_address(b_mra),
    .mem_read_ready(b_mrr), .mem_read_data(b_mrd),
    .mem_write_valid(b_mwv), .mem_write_address(b_mwa),
    .mem_write_data(b_mwd), .mem_write_ready(b_mwr)
  );

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs are driven and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_n = 1'b0;
    a_crv = '0; a_cra = '0; a_cwv = '0; a_cwa = '0; a_cwd = '0;
    a_mrr = '0; a_mrd = '0; a_mwr = '0;
    b_crv = '0; b_cra = '0; b_cwv = '0; b_cwa = '0; b_cwd = '0;
    b_mrr = '0; b_mrd = '0; b_mwr = '0;

    // Reset state
    #12;
    check("rst_mem_rd_valid", 32'(a_mrv), 32'h0);
    check("rst_mem_rd_addr",  32'(a_mra), 32'h0);
    check("rst_mem_wr_valid", 32'(a_mwv), 32'h0);
    check("rst_cons_rd_rdy",  32'(a_crr), 32'h0);
    check("rst_cons_wr_rdy",  32'(a_cwr), 32'h0);
    check("rst_cons_rd_data", a_crd,      32'h0);
    check("rst_b_mem_rd_valid", 32'(b_mrv), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single read: consumer 0 reads 0x12, memory returns 0x5A after a 2-cycle delay
    a_cra = 32'h0000_0012;
    a_crv = 4'b0001;
    step();
    check("rd_claim_valid", 32'(a_mrv), 32'h1);
    check("rd_claim_addr",  32'(a_mra), 32'h12);
    step();
    check("rd_hold1_valid", 32'(a_mrv), 32'h1);
    step();
    check("rd_hold2_valid", 32'(a_mrv), 32'h1);
    check("rd_hold2_addr",  32'(a_mra), 32'h12);
    check("rd_hold2_rdy",   32'(a_crr), 32'h0);
    a_mrr = 1'b1; a_mrd = 8'h5A;
    step();
    check("rd_ack_valid", 32'(a_mrv), 32'h0);
    check("rd_ack_rdy",   32'(a_crr), 32'h1);
    check("rd_ack_data",  a_crd,      32'h5A);
    a_mrr = 1'b0; a_mrd = 8'h00;
    step();
    check("rd_relay_rdy", 32'(a_crr), 32'h1);
    a_crv = 4'b0000;
    step();
    check("rd_drop_rdy",  32'(a_crr), 32'h0);
    check("rd_data_hold", a_crd,      32'h5A);

    // Single write: consumer 2 writes 0x33 to address 0x40
    a_cwa = 32'h0040_0000;
    a_cwd = 32'h0033_0000;
    a_cwv = 4'b0100;
    step();
`ifdef MEM_ARB_WRITE_EN
    check("wr_claim_valid", 32'(a_mwv), 32'h1);
    check("wr_claim_addr",  32'(a_mwa), 32'h40);
    check("wr_claim_data",  32'(a_mwd), 32'h33);
    a_mwr = 1'b1;
    step();
    check("wr_ack_valid", 32'(a_mwv), 32'h0);
    check("wr_ack_rdy",   32'(a_cwr), 32'h4);
    a_mwr = 1'b0;
    a_cwv = 4'b0000;
    step();
    check("wr_drop_rdy", 32'(a_cwr), 32'h0);
`else
    check("wr_off_valid",    32'(a_mwv), 32'h0);
    check("wr_off_rd_valid", 32'(a_mrv), 32'h0);
    step();
    check("wr_off_rdy",      32'(a_cwr), 32'h0);
    a_cwv = 4'b0000;
    step();
`endif

    // Contention on one channel: consumers 0..3 read at the same time
    a_cra = 32'h1312_1110;
    a_crv = 4'b1111;
    for (int j = 0; j < 4; j++) begin
      step();
      check("cont_claim_valid", 32'(a_mrv), 32'h1);
      check("cont_claim_addr",  32'(a_mra), 32'h10 + j);
      a_mrr = 1'b1;
      a_mrd = 8'(8'hC0 + j);
      step();
      check("cont_grant_rdy", 32'(a_crr), 32'h1 << j);
      a_mrr = 1'b0;
      a_crv[j] = 1'b0;
      step();
      check("cont_release_rdy",   32'(a_crr), 32'h0);
      check("cont_release_valid", 32'(a_mrv), 32'h0);
    end
    check("cont_all_data", a_crd, 32'hC3C2_C1C0);

    // Read and write both valid on consumer 0: the read goes first
    a_cra = 32'h0000_0021;
    a_cwa = 32'h0000_0022;
    a_cwd = 32'h0000_0077;
    a_crv = 4'b0001;
    a_cwv = 4'b0001;
    step();
    check("rw_read_first", 32'(a_mrv), 32'h1);
    check("rw_no_write",   32'(a_mwv), 32'h0);
    a_mrr = 1'b1; a_mrd = 8'h99;
    step();
    check("rw_read_rdy", 32'(a_crr), 32'h1);
    a_mrr = 1'b0;
    a_crv = 4'b0000;
    step();
    check("rw_read_drop", 32'(a_crr), 32'h0);
    step();
`ifdef MEM_ARB_WRITE_EN
    check("rw_write_valid", 32'(a_mwv), 32'h1);
    check("rw_write_addr",  32'(a_mwa), 32'h22);
    check("rw_write_data",  32'(a_mwd), 32'h77);
    a_mwr = 1'b1;
    step();
    check("rw_write_rdy", 32'(a_cwr), 32'h1);
    a_mwr = 1'b0;
    a_cwv = 4'b0000;
    step();
    check("rw_write_drop", 32'(a_cwr), 32'h0);
`else
    check("rw_off_write_valid", 32'(a_mwv), 32'h0);
    check("rw_off_read_valid",  32'(a_mrv), 32'h0);
    a_cwv = 4'b0000;
    step();
`endif
    check("rw_data", a_crd, 32'hC3C2_C199);

    // Two channels: consumers 1 and 3 are claimed on the same edge
    b_cra = 32'h3300_3100;
    b_crv = 4'b1010;
    step();
    check("dual_valid", 32'(b_mrv), 32'h3);
    check("dual_addr",  32'(b_mra), 32'h3331);
    b_mrr = 2'b11;
    b_mrd = 16'hB3B1;
    step();
    check("dual_rdy",   32'(b_crr), 32'hA);
    check("dual_data",  b_crd,      32'hB300_B100);
    check("dual_drop_valid", 32'(b_mrv), 32'h0);
    b_mrr = 2'b00;
    b_crv = 4'b0000;
    step();
    check("dual_release", 32'(b_crr), 32'h0);

    // Reset during READ_WAIT, then reissue the request
    a_cra = 32'h0000_5500;
    a_crv = 4'b0010;
    step();
    check("rstmid_claim", 32'(a_mrv), 32'h1);
    check("rstmid_addr",  32'(a_mra), 32'h55);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstmid_valid_drop", 32'(a_mrv), 32'h0);
    check("rstmid_rdy",        32'(a_crr), 32'h0);
    check("rstmid_data",       a_crd,      32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step();
    check("rstmid_reclaim_valid", 32'(a_mrv), 32'h1);
    check("rstmid_reclaim_addr",  32'(a_mra), 32'h55);
    a_mrr = 1'b1; a_mrd = 8'h66;
    step();
    check("rstmid_done_rdy",  32'(a_crr), 32'h2);
    check("rstmid_done_data", a_crd,      32'h0000_6600);
    a_mrr = 1'b0;
    a_crv = 4'b0000;
    step();
    check("rstmid_release", 32'(a_crr), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_req_arbiter.md
# mem_req_arbiter

Memory request arbiter that sits between the per-thread memory consumers of the GPU (LSUs or fetchers) and the external memory channels served by `mem_wrapper`. It is the initiator side of the valid/ready memory protocol. It multiplexes `NUM_CONSUMERS` request ports onto `NUM_CHANNELS` memory channels, holds each memory request until the responder acknowledges it, and relays read data and write acknowledgements back to the requesting consumer.

## Interface
Parameters:
- `ADDR_BITS`, 8, memory address width.
- `DATA_BITS`, 8, memory data width.
- `NUM_CONSUMERS`, 4, number of requesting ports (≥1).
- `NUM_CHANNELS`, 1, number of memory channels (1..NUM_CONSUMERS).

Ports. Buses are flat, and consumer/channel i occupies slice i:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `consumer_read_valid` in NUM_CONSUMERS: read request.
- `consumer_read_address` in ADDR_BITS*NUM_CONSUMERS: read address.
- `consumer_read_ready` out NUM_CONSUMERS: read data valid / ack.
- `consumer_read_data` out DATA_BITS*NUM_CONSUMERS: read data.
- `consumer_write_valid` in NUM_CONSUMERS: write request.
- `consumer_write_address` in ADDR_BITS*NUM_CONSUMERS: write address.
- `consumer_write_data` in DATA_BITS*NUM_CONSUMERS: write data.
- `consumer_write_ready` out NUM_CONSUMERS: write ack.
- `mem_read_valid` out NUM_CHANNELS: read request to memory.
- `mem_read_address` out ADDR_BITS*NUM_CHANNELS: read address to memory.
- `mem_read_ready` in NUM_CHANNELS: memory read ack; data valid.
- `mem_read_data` in DATA_BITS*NUM_CHANNELS: memory read data.
- `mem_write_valid` out NUM_CHANNELS: write request to memory.
- `mem_write_address` out ADDR_BITS*NUM_CHANNELS: write address.
- `mem_write_data` out DATA_BITS*NUM_CHANNELS: write data.
- `mem_write_ready` in NUM_CHANNELS: memory write ack.

## Operation
- Each channel has its own FSM with states IDLE, READ_WAIT, WRITE_WAIT, READ_RELAY and WRITE_RELAY.
- A `serving` bitmask of NUM_CONSUMERS bits marks consumers already owned by a channel.
- **IDLE:** the channel claims the lowest-index consumer that has a valid request and is not in `serving`.
  - Channels evaluate in index order within one cycle, so a consumer claimed by channel c is not visible to channel c+1 that cycle.
  - If the claimed consumer has read valid, the channel goes to READ_WAIT. Otherwise it goes to WRITE_WAIT. Read wins when both are valid.
  - Address and data are registered on claim.
- **READ_WAIT:** `mem_read_valid`=1 and the address is held stable.
  - On `mem_read_ready`=1, capture `mem_read_data` into the consumer data register.
  - Drop `mem_read_valid` and go to READ_RELAY.
- **WRITE_WAIT:** `mem_write_valid`=1 with address and data held.
  - On `mem_write_ready`=1, drop valid and go to WRITE_RELAY.
- **READ_RELAY / WRITE_RELAY:** the consumer ready output is 1 and is held until the consumer deasserts its valid.
  - Then ready goes 0, the `serving` bit is cleared and the channel returns to IDLE.
- Consumer data output holds its last captured value until the next read completes for that consumer.
- A consumer never has more than one outstanding transaction.
- No timeout exists; a channel waits indefinitely for ready.

## Timing
- All outputs are registered.
- On reset:
  - All `mem_*_valid`, `consumer_*_ready`, addresses and data are 0.
  - All FSMs are IDLE and `serving` is 0.
- Claim latency: consumer valid is sampled at edge k; `mem_*_valid` is high after edge k.
- Memory ready sampled at edge m gives:
  - `mem_*_valid` low after edge m.
  - `consumer_*_ready` high after edge m.
- Consumer valid sampled low at edge r gives `consumer_*_ready` low after edge r; the channel can claim again at edge r+1.
- Minimum read round trip with a same-cycle responder and a consumer that drops valid immediately: 3 cycles per transaction per channel.
- Reset mid-transaction aborts immediately:
  - The request is dropped and must be reissued by the consumer.
  - The memory side sees valid fall asynchronously.

## Configuration
- `MEM_ARB_WRITE_EN` defined: write path is present as described.
- `MEM_ARB_WRITE_EN` undefined:
  - WRITE_WAIT and WRITE_RELAY are removed.
  - `mem_write_valid`, `mem_write_address`, `mem_write_data` and `consumer_write_ready` are tied to 0.
  - `consumer_write_valid` is ignored and never claims a channel. This is used for the read-only program memory.

## Test plan
- Single read: consumer 0 reads addr 0x12; memory returns 0x5A with 2-cycle ready delay.
  - `mem_read_address`=0x12, held until ready.
  - `consumer_read_data[7:0]`=0x5A with ready=1 until valid drops.
- Single write (macro on): consumer 2 writes 0x33 to 0x40.
  - `mem_write_*` shows 0x40/0x33.
  - `consumer_write_ready[2]` pulses after the memory ack.
  - With macro off: no `mem_write_valid` and no ready.
- Contention with NUM_CHANNELS=1: consumers 0–3 read simultaneously.
  - Serviced in order 0,1,2,3, each receiving its own address's data.
  - No consumer is granted twice.
- Two channels: consumers 1 and 3 request in the same cycle.
  - Channel 0 serves consumer 1 and channel 1 serves consumer 3, both claimed on the same edge.
- Read-and-write both valid on consumer 0: read is performed first.
  - After relay completes, with write still valid, the write is claimed next.
- Reset asserted during READ_WAIT: all valids and readies go 0 immediately.
  - After release, a new request completes normally.
